debounce_core: RTL and testbench
================================

# debounce_core

MMIO slot core that debounces a bank of raw mechanical inputs (switches/buttons) and latches per-bit rising and falling edge events for software polling. It plugs into one slot of the MMIO subsystem through the standard slot interface and consumes the controller's per-slot cs/read/write/reg_addr/wr_data signals. It is the debounced alternative to the plain GPI slot.

## Interface
Parameters:
- W, 8: number of input bits (1..32)
- DEFAULT_PERIOD, 16'd50000: debounce period loaded at reset, in clk cycles

Ports:
- clk  input  1  system clock; one clock domain
- reset  input  1  synchronous, active-high reset
- cs  input  1  slot chip select
- read  input  1  slot read strobe; no side effects
- write  input  1  slot write strobe; effective when cs && write
- reg_addr  input  5  register index within slot
- wr_data  input  32  write data
- rd_data  output  32  read data, combinational on reg_addr
- din  input  W  raw asynchronous inputs

## Operation
- Per bit: 2-FF synchronizer (s1, s2), 16-bit stability counter cnt, debounced level lvl.
- Each cycle, per bit: if s2 == lvl then cnt <= 0; else if cnt >= P_eff-1 then lvl <= s2, cnt <= 0, set edge event; else cnt <= cnt+1.
- P_eff = period register, except 0 treated as 1.
- Edge events: lvl 0->1 sets rise[i]; lvl 1->0 sets fall[i]. Sticky until cleared by software.
- Register map (word index reg_addr):
  - 0 LEVEL (RO): {zeros, lvl[W-1:0]}
  - 1 RISE (R/W1C): read rise; write clears bits where wr_data[i]=1
  - 2 FALL (R/W1C): read fall; same clear rule
  - 3 PERIOD (R/W): wr_data[15:0] -> period; read {16'b0, period}
  - 4..31: read 32'h0; writes ignored
- Writes to LEVEL ignored.
- Writing PERIOD clears all cnt on the same edge; lvl, rise and fall unchanged.
- Simultaneous event set and W1C clear on the same bit in the same cycle: set wins (bit reads 1 afterward).
- Unused upper rd_data bits are always 0; W bits zero-extended.

## Timing
- Reset values: lvl=0, s1=s2=0, cnt=0, rise=0, fall=0, period=DEFAULT_PERIOD. rd_data follows the register mux, so it reads 0 for every address except 3.
- Reset is checked before all other logic and may land at any cycle, including mid-count. All state returns to reset values on that edge.
- rd_data is purely combinational from reg_addr and the current registers. It is valid in the same cycle, independent of cs/read.
- Writes take effect on the clock edge where cs && write is high.
- Latency: din[i] stable at a new value before edge k is captured in s1 at k and in s2 at k+1. lvl[i] and the event bit update at edge k+1+P_eff, provided din stays stable throughout.
- A glitch shorter than P_eff cycles at s2 resets cnt and produces no lvl change and no event.
- cnt never wraps. It is bounded by P_eff-1 ≤ 65534.
- din held high through reset: after reset release, lvl rises at edge 2+P_eff and rise is set. This is intended.

## Test plan
- Reset, then read addresses 0..4: 0, 0, 0, DEFAULT_PERIOD, 0. Write addr 0 = 32'hFF, then read addr 0 = 0.
- Write PERIOD=4, then step din[0] 0->1 before edge k: LEVEL bit0=1 exactly after edge k+5, not before. RISE=32'h1 and FALL=0.
- PERIOD=4, pulse din[3] high for 3 cycles: LEVEL, RISE and FALL stay 0. Repeat with 5 stable cycles: LEVEL bit3 toggles 0->1->0 and RISE=FALL=32'h8.
- With RISE=32'h3, write addr 1 wr_data=32'h1: RISE=32'h2. Then coincide a W1C of bit1 with a new bit1 rising event on the same edge: RISE bit1 reads 1.
- PERIOD=0: a din step is reflected one cycle after the s2 change (same as PERIOD=1). Writing PERIOD=10 mid-count restarts the count, so lvl updates 10 cycles after that write edge.
- Assert reset mid-count with rise/fall nonzero: all registers return to reset values on that edge and PERIOD reads DEFAULT_PERIOD.

Source files
------------

// File: rtl/debounce_core.sv
// rtl/debounce_core.sv - debounced input bank with sticky edge events on an MMIO slot
//
// Purpose: synchronizes and debounces W raw inputs. A bit's debounced level
// follows its synchronized input only after that input has held its new value
// for P_eff consecutive cycles. Every level change latches a sticky rise or
// fall event that software clears with write-one-to-clear.
//
// Ports:
//   clk       system clock (single domain)
//   reset     synchronous, active-high reset
//   cs        slot chip select
//   read      slot read strobe (reads have no side effects)
//   write     slot write strobe; a write happens when cs && write
//   reg_addr  register word index: 0 LEVEL, 1 RISE, 2 FALL, 3 PERIOD
//   wr_data   write data
//   rd_data   read data, combinational on reg_addr
//   din       raw asynchronous inputs

module debounce_core #(
  parameter int          W              = 8,
  parameter logic [15:0] DEFAULT_PERIOD = 16'd50000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cs,
  input  logic         read,
  input  logic         write,
  input  logic [4:0]   reg_addr,
  input  logic [31:0]  wr_data,
  output logic [31:0]  rd_data,
  input  logic [W-1:0] din
);

  localparam logic [4:0] ADDR_LEVEL  = 5'd0;
  localparam logic [4:0] ADDR_RISE   = 5'd1;
  localparam logic [4:0] ADDR_FALL   = 5'd2;
  localparam logic [4:0] ADDR_PERIOD = 5'd3;

  logic [W-1:0] s1_q, s2_q;
  logic [W-1:0] lvl_q, lvl_d;
  logic [W-1:0] rise_q, rise_d;
  logic [W-1:0] fall_q, fall_d;
  logic [15:0]  period_q, period_d;
  logic [15:0]  cnt_q [W];
  logic [15:0]  cnt_d [W];

  logic        wr_en;
  logic [15:0] p_eff_m1;

  // The read strobe carries no side effects, and only part of wr_data is
  // stored for narrow banks.
  logic unused_inputs;
  assign unused_inputs = ^{read, wr_data};

  assign wr_en = cs && write;

  // A period of 0 behaves as 1, so the threshold never underflows.
  assign p_eff_m1 = (period_q == 16'd0) ? 16'd0 : (period_q - 16'd1);

  always_comb begin
    lvl_d    = lvl_q;
    rise_d   = rise_q;
    fall_d   = fall_q;
    period_d = period_q;
    cnt_d    = cnt_q;

    // Clears are applied first so a new event on the same edge overrides them.
    if (wr_en && (reg_addr == ADDR_RISE)) begin
      rise_d = rise_q & ~wr_data[W-1:0];
    end
    if (wr_en && (reg_addr == ADDR_FALL)) begin
      fall_d = fall_q & ~wr_data[W-1:0];
    end

    for (int i = 0; i < W; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = 16'd0;
      end else if (cnt_q[i] >= p_eff_m1) begin
        lvl_d[i] = s2_q[i];
        cnt_d[i] = 16'd0;
        if (s2_q[i]) begin
          rise_d[i] = 1'b1;
        end else begin
          fall_d[i] = 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end

    // A new period restarts every pending stability count from zero.
    if (wr_en && (reg_addr == ADDR_PERIOD)) begin
      period_d = wr_data[15:0];
      for (int i = 0; i < W; i++) begin
        cnt_d[i] = 16'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      lvl_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      period_q <= DEFAULT_PERIOD;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      s1_q     <= din;
      s2_q     <= s1_q;
      lvl_q    <= lvl_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      period_q <= period_d;
      for (int i = 0; i < W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    case (reg_addr)
      ADDR_LEVEL:  rd_data[W-1:0] = lvl_q;
      ADDR_RISE:   rd_data[W-1:0] = rise_q;
      ADDR_FALL:   rd_data[W-1:0] = fall_q;
      ADDR_PERIOD: rd_data[15:0]  = period_q;
      default:     rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_debounce_core.sv
// tb/tb_debounce_core.sv - scoreboard bench for debounce_core

module tb_debounce_core;

  localparam int          W    = 8;
  localparam logic [15:0] DEFP = 16'd50000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cs;
  logic         read;
  logic         write;
  logic [4:0]   reg_addr;
  logic [31:0]  wr_data;
  logic [31:0]  rd_data;
  logic [W-1:0] din;

  debounce_core #(.W(W), .DEFAULT_PERIOD(DEFP)) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .read     (read),
    .write    (write),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .din      (din)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  // Monitor: whenever the bench presents a read, pop the expected word.
  always @(negedge clk) begin
    if (cs && read) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %h required no read pending", rd_data);
      end else begin
        cur = exp_q.pop_front();
        if (rd_data !== cur.val) begin
          errors++;
          $display("FAIL %s: got %h required %h", cur.name, rd_data, cur.val);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [31:0] val, input string name);
    exp_t e;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
    cs       = 1'b1;
    read     = 1'b1;
    write    = 1'b0;
    reg_addr = addr;
    @(negedge clk);
    #1;
    cs   = 1'b0;
    read = 1'b0;
  endtask

  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    cs       = 1'b1;
    write    = 1'b1;
    read     = 1'b0;
    reg_addr = addr;
    wr_data  = data;
    @(posedge clk);
    #1;
    cs    = 1'b0;
    write = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0;
    reg_addr = 5'd0; wr_data = 32'd0; din = '0;
    tick(3);
    reset = 1'b0;

    // Reset values and address decode
    do_read(5'd0,  32'h0, "rst_level");
    do_read(5'd1,  32'h0, "rst_rise");
    do_read(5'd2,  32'h0, "rst_fall");
    do_read(5'd3,  32'h0000C350, "rst_period");
    do_read(5'd4,  32'h0, "rst_addr4");
    do_read(5'd31, 32'h0, "rst_addr31");
    do_write(5'd0, 32'hFF);
    do_read(5'd0, 32'h0, "level_ro");
    do_write(5'd5, 32'hFFFF_FFFF);
    do_read(5'd5, 32'h0, "addr5_ignored");
    do_read(5'd3, 32'h0000C350, "period_untouched");

    // Latency with PERIOD=4: lvl updates exactly at edge k+5
    do_write(5'd3, 32'hFFFF_0004);
    do_read(5'd3, 32'h4, "period_wr4");
    din = 8'h01;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      do_read(5'd0, 32'h0, $sformatf("lat_early_k%0d", j));
    end
    tick(1);
    do_read(5'd0, 32'h1, "lat_k5");
    do_read(5'd1, 32'h1, "lat_rise");
    do_read(5'd2, 32'h0, "lat_fall");
    do_write(5'd1, 32'hFF);
    do_read(5'd1, 32'h0, "rise_clr_all");

    // Glitch of 3 cycles on bit3 is filtered
    din = 8'h09;
    tick(3);
    din = 8'h01;
    tick(10);
    do_read(5'd0, 32'h1, "glitch_level");
    do_read(5'd1, 32'h0, "glitch_rise");
    do_read(5'd2, 32'h0, "glitch_fall");

    // 5 stable cycles on bit3 pass through, then fall back
    din = 8'h09;
    tick(5);
    din = 8'h01;
    tick(1);
    do_read(5'd0, 32'h9, "pulse5_high");
    tick(10);
    do_read(5'd0, 32'h1, "pulse5_low");
    do_read(5'd1, 32'h8, "pulse5_rise");
    do_read(5'd2, 32'h8, "pulse5_fall");
    do_write(5'd1, 32'hFF);
    do_write(5'd2, 32'hFF);
    do_read(5'd1, 32'h0, "rise_clr2");
    do_read(5'd2, 32'h0, "fall_clr2");

    // W1C of a single bit
    din = 8'h00;
    tick(10);
    do_write(5'd1, 32'hFF);
    do_write(5'd2, 32'hFF);
    din = 8'h03;
    tick(10);
    do_read(5'd1, 32'h3, "rise_both");
    do_write(5'd1, 32'h1);
    do_read(5'd1, 32'h2, "w1c_bit0");

    // Set wins over a coincident W1C clear
    din = 8'h01;
    tick(10);
    do_write(5'd1, 32'hFF);
    do_read(5'd1, 32'h0, "rise_clr3");
    din = 8'h03;
    tick(5);
    do_write(5'd1, 32'h2);
    do_read(5'd1, 32'h2, "set_wins");
    do_read(5'd0, 32'h3, "set_wins_level");

    // PERIOD=0 behaves as 1
    do_write(5'd3, 32'h0);
    do_read(5'd3, 32'h0, "period_wr0");
    din = 8'h07;
    tick(1);
    do_read(5'd0, 32'h3, "p0_k0");
    tick(1);
    do_read(5'd0, 32'h3, "p0_k1");
    tick(1);
    do_read(5'd0, 32'h7, "p0_k2");

    // Writing PERIOD mid-count restarts the count
    do_write(5'd3, 32'd100);
    din = 8'h17;
    tick(20);
    do_write(5'd3, 32'd10);
    tick(9);
    do_read(5'd0, 32'h7, "restart_early");
    tick(1);
    do_read(5'd0, 32'h17, "restart_k10");
    do_read(5'd3, 32'd10, "period_rd10");

    // Reset mid-count with events pending
    din = 8'h37;
    tick(3);
    do_read(5'd1, 32'h16, "pre_rst_rise");
    reset = 1'b1;
    tick(1);
    do_read(5'd0, 32'h0, "mid_rst_level");
    do_read(5'd1, 32'h0, "mid_rst_rise");
    do_read(5'd2, 32'h0, "mid_rst_fall");
    do_read(5'd3, 32'h0000C350, "mid_rst_period");
    reset = 1'b0;
    tick(20);
    do_read(5'd0, 32'h0, "post_rst_level");

    tick(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
